// File: rtl/hb_int_sched.sv
// hb_int_sched -- rate scheduler and strobe sequencer for the TX interpolation
// chain (input FIFO -> halfband A -> halfband B -> CIC).
//
// At a run rising edge the total interpolation N is latched and split into a
// halfband stage count k and a CIC rate N>>k. While running, a phase counter
// cnt walks 0..N-1 and every stage strobe is decoded from it. Stopping always
// completes the current N-cycle period.
//
// Ports:
//   clk_i, rst_i              clock, async active-high reset
//   run_i                     level; rise starts, fall requests stop
//   interp_rate_i[7:0]        total interpolation N, sampled in IDLE
//   src_valid_i               upstream FIFO has a sample
//   src_ready_o               pop request (same as stb_a_in_o)
//   stb_*_o                   per-stage input/output strobes
//   bypass_a_o, bypass_b_o    halfband bypass controls
//   output_rate_a_o/_b_o      clocks between output strobes of each halfband
//   cic_rate_o                CIC interpolation
//   stages_o                  halfband stages in use
//   active_o                  high in RUN and DRAIN
//   zero_fill_o               current period carries zeros (underrun)
//   underrun_o                sticky underrun flag
//   done_o                    one-cycle pulse on return to IDLE after a stop
//   cfg_err_o                 sticky; N=0 presented at start
module hb_int_sched (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       run_i,
    input  logic [7:0] interp_rate_i,
    input  logic       src_valid_i,
    output logic       src_ready_o,
    output logic       stb_a_in_o,
    output logic       stb_a_out_o,
    output logic       stb_b_in_o,
    output logic       stb_b_out_o,
    output logic       stb_cic_o,
    output logic       bypass_a_o,
    output logic       bypass_b_o,
    output logic [7:0] output_rate_a_o,
    output logic [7:0] output_rate_b_o,
    output logic [7:0] cic_rate_o,
    output logic [1:0] stages_o,
    output logic       active_o,
    output logic       zero_fill_o,
    output logic       underrun_o,
    output logic       done_o,
    output logic       cfg_err_o
);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_t;

    state_t     state_q;
    logic [7:0] n_q, cnt_q, sub_q;
    logic       run_q;
    logic       stb_a_in_q, stb_a_out_q, stb_cic_q;
    logic       bypass_a_q, bypass_b_q;
    logic [7:0] rate_a_q, rate_b_q, cic_rate_q;
    logic [1:0] stages_q;
    logic       active_q, zero_fill_q, underrun_q, done_q, cfg_err_q;

    logic [1:0] k_d;
    logic [7:0] cnt_d, sub_d;
    logic       stb_a_in_d, stb_a_out_d, stb_cic_d;
    logic       last_q;

    // Stage split for a candidate N. Each enabled halfband needs its input
    // spacing to be at least 8 clocks, hence the N>=8 / N>=16 floors.
    always_comb begin
        k_d = 2'd0;
        if (interp_rate_i[1:0] == 2'b00 && interp_rate_i >= 8'd16)
            k_d = 2'd2;
        else if (!interp_rate_i[0] && interp_rate_i >= 8'd8)
            k_d = 2'd1;
    end

    // Next phase. sub_q is a secondary counter wrapping at cic_rate so the
    // CIC / stage-B-output strobe needs no divider. Entry from PRIME is phase 0.
    assign last_q = (cnt_q == n_q - 8'd1);

    always_comb begin
        if (state_q == PRIME) begin
            cnt_d = 8'd0;
            sub_d = 8'd0;
        end else begin
            cnt_d = last_q ? 8'd0 : cnt_q + 8'd1;
            sub_d = (cnt_d == 8'd0 || sub_q == cic_rate_q - 8'd1) ? 8'd0 : sub_q + 8'd1;
        end
        stb_a_in_d  = (cnt_d == 8'd0);
        stb_a_out_d = (cnt_d == 8'd0) || (stages_q != 2'd0 && cnt_d == {1'b0, n_q[7:1]});
        stb_cic_d   = (sub_d == 8'd0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            n_q         <= 8'd0;
            cnt_q       <= 8'd0;
            sub_q       <= 8'd0;
            run_q       <= 1'b0;
            stb_a_in_q  <= 1'b0;
            stb_a_out_q <= 1'b0;
            stb_cic_q   <= 1'b0;
            bypass_a_q  <= 1'b1;
            bypass_b_q  <= 1'b1;
            rate_a_q    <= 8'd0;
            rate_b_q    <= 8'd0;
            cic_rate_q  <= 8'd1;
            stages_q    <= 2'd0;
            active_q    <= 1'b0;
            zero_fill_q <= 1'b0;
            underrun_q  <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            run_q       <= run_i;
            done_q      <= 1'b0;
            stb_a_in_q  <= 1'b0;
            stb_a_out_q <= 1'b0;
            stb_cic_q   <= 1'b0;
            active_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (run_i && !run_q) begin
                        if (interp_rate_i == 8'd0) begin
                            cfg_err_q <= 1'b1;
                        end else begin
                            n_q        <= interp_rate_i;
                            stages_q   <= k_d;
                            bypass_a_q <= (k_d == 2'd0);
                            bypass_b_q <= (k_d != 2'd2);
                            cic_rate_q <= interp_rate_i >> k_d;
                            rate_a_q   <= (k_d != 2'd0) ? interp_rate_i >> 1 : 8'd0;
                            rate_b_q   <= (k_d == 2'd2) ? interp_rate_i >> 2 : 8'd0;
                            cfg_err_q  <= 1'b0;
                            underrun_q <= 1'b0;
                            state_q    <= PRIME;
                        end
                    end
                end
                PRIME: begin
                    if (!run_i) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else if (src_valid_i) begin
                        state_q     <= RUN;
                        cnt_q       <= cnt_d;
                        sub_q       <= sub_d;
                        stb_a_in_q  <= stb_a_in_d;
                        stb_a_out_q <= stb_a_out_d;
                        stb_cic_q   <= stb_cic_d;
                        active_q    <= 1'b1;
                        zero_fill_q <= 1'b0;
                    end
                end
                default: begin // RUN, DRAIN
                    // A stop only takes effect at a period boundary.
                    if (last_q && (state_q == DRAIN || !run_i)) begin
                        state_q     <= IDLE;
                        done_q      <= 1'b1;
                        cnt_q       <= 8'd0;
                        sub_q       <= 8'd0;
                        zero_fill_q <= 1'b0;
                    end else begin
                        if (state_q == RUN && !run_i)
                            state_q <= DRAIN;
                        cnt_q       <= cnt_d;
                        sub_q       <= sub_d;
                        stb_a_in_q  <= stb_a_in_d;
                        stb_a_out_q <= stb_a_out_d;
                        stb_cic_q   <= stb_cic_d;
                        active_q    <= 1'b1;
                        // The pop decision at a period start fixes the whole period.
                        if (cnt_d == 8'd0) begin
                            zero_fill_q <= !src_valid_i;
                            if (!src_valid_i)
                                underrun_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign src_ready_o     = stb_a_in_q;
    assign stb_a_in_o      = stb_a_in_q;
    assign stb_a_out_o     = stb_a_out_q;
    assign stb_b_in_o      = stb_a_out_q;
    assign stb_b_out_o     = stb_cic_q;
    assign stb_cic_o       = stb_cic_q;
    assign bypass_a_o      = bypass_a_q;
    assign bypass_b_o      = bypass_b_q;
    assign output_rate_a_o = rate_a_q;
    assign output_rate_b_o = rate_b_q;
    assign cic_rate_o      = cic_rate_q;
    assign stages_o        = stages_q;
    assign active_o        = active_q;
    assign zero_fill_o     = zero_fill_q;
    assign underrun_o      = underrun_q;
    assign done_o          = done_q;
    assign cfg_err_o       = cfg_err_q;

endmodule

// File: tb/tb_hb_int_sched.sv
// Testbench for hb_int_sched: behavioural model (phase arithmetic with modulo
// strobe rules) compared every cycle, plus literal spot checks.
module tb_hb_int_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [7:0] nin = 8'd0;
    logic       sv  = 1'b0;

    logic       src_ready, stb_a_in, stb_a_out, stb_b_in, stb_b_out, stb_cic;
    logic       bypass_a, bypass_b, active, zero_fill, underrun, done, cfg_err;
    logic [7:0] rate_a, rate_b, cic_rate;
    logic [1:0] stages;

    int n_chk  = 0;
    int n_fail = 0;
    int zf_cnt = 0;

    // model state: st 0=idle 1=prime 2=run 3=drain
    int m_st, m_ph, m_N, m_k, m_runq, m_zf, m_un, m_ce, m_done;

    always #5 clk = ~clk;

    hb_int_sched dut (
        .clk_i(clk), .rst_i(rst), .run_i(run), .interp_rate_i(nin), .src_valid_i(sv),
        .src_ready_o(src_ready), .stb_a_in_o(stb_a_in), .stb_a_out_o(stb_a_out),
        .stb_b_in_o(stb_b_in), .stb_b_out_o(stb_b_out), .stb_cic_o(stb_cic),
        .bypass_a_o(bypass_a), .bypass_b_o(bypass_b),
        .output_rate_a_o(rate_a), .output_rate_b_o(rate_b), .cic_rate_o(cic_rate),
        .stages_o(stages), .active_o(active), .zero_fill_o(zero_fill),
        .underrun_o(underrun), .done_o(done), .cfg_err_o(cfg_err)
    );

    task automatic model_reset();
        m_st = 0; m_ph = 0; m_N = 0; m_k = 0; m_runq = 0;
        m_zf = 0; m_un = 0; m_ce = 0; m_done = 0;
    endtask

    task automatic model_step(input int r, input int n_in, input int v);
        m_done = 0;
        case (m_st)
            0: if (r != 0 && m_runq == 0) begin
                if (n_in == 0) m_ce = 1;
                else begin
                    m_N = n_in;
                    if (n_in % 4 == 0 && n_in >= 16)     m_k = 2;
                    else if (n_in % 2 == 0 && n_in >= 8) m_k = 1;
                    else                                   m_k = 0;
                    m_ce = 0; m_un = 0; m_st = 1;
                end
            end
            1: if (r == 0) begin m_st = 0; m_done = 1; end
               else if (v != 0) begin m_st = 2; m_ph = 0; m_zf = 0; end
            default: begin
                if (m_ph == m_N - 1 && (m_st == 3 || r == 0)) begin
                    m_st = 0; m_done = 1; m_zf = 0;
                end else begin
                    m_ph = (m_ph + 1) % m_N;
                    if (m_st == 2 && r == 0) m_st = 3;
                    if (m_ph == 0) begin
                        m_zf = (v == 0) ? 1 : 0;
                        if (v == 0) m_un = 1;
                    end
                end
            end
        endcase
        m_runq = r;
    endtask

    // {ready,a_in,a_out,b_in,b_out,cic,byp_a,byp_b,rate_a,rate_b,cic_rate,stages,active,zf,un,done,cfg_err}
    function automatic logic [38:0] model_vec();
        logic act, ain, aout, cs, ba, bb;
        logic [7:0] ra, rb, cr;
        logic [1:0] kk;
        act = (m_st >= 2);
        ain = 0; aout = 0; cs = 0;
        if (act) begin
            ain  = (m_ph == 0);
            aout = (m_ph % ((m_k == 0) ? m_N : m_N / 2)) == 0;
            cs   = (m_ph % (m_N >> m_k)) == 0;
        end
        if (m_N == 0) begin
            ba = 1; bb = 1; ra = 0; rb = 0; cr = 1; kk = 0;
        end else begin
            ba = (m_k == 0); bb = (m_k < 2);
            ra = (m_k >= 1) ? 8'(m_N / 2) : 8'd0;
            rb = (m_k == 2) ? 8'(m_N / 4) : 8'd0;
            cr = 8'(m_N >> m_k); kk = 2'(m_k);
        end
        return {ain, ain, aout, aout, cs, cs, ba, bb, ra, rb, cr, kk, act,
                1'(m_zf), 1'(m_un), 1'(m_done), 1'(m_ce)};
    endfunction

    function automatic logic [38:0] dut_vec();
        return {src_ready, stb_a_in, stb_a_out, stb_b_in, stb_b_out, stb_cic,
                bypass_a, bypass_b, rate_a, rate_b, cic_rate, stages, active,
                zero_fill, underrun, done, cfg_err};
    endfunction

    localparam logic [38:0] RST_VEC = {6'b0, 2'b11, 8'd0, 8'd0, 8'd1, 2'd0, 5'b0};

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) model_reset();
            else model_step(int'(run), int'(nin), int'(sv));
            #1;
            if (zero_fill) zf_cnt++;
            n_chk++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL outputs: got %h expected %h (model st=%0d ph=%0d N=%0d) at %0t",
                         dut_vec(), model_vec(), m_st, m_ph, m_N, $time);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ph(input int p);
        int b = 0;
        while (!(m_st >= 2 && m_ph == p) && b < 300) begin @(negedge clk); b++; end
        if (b >= 300) chk("wait_ph_timeout", b, 0);
    endtask

    task automatic stop_and_idle();
        int b = 0;
        run = 1'b0;
        @(negedge clk);
        while ((active || m_st != 0) && b < 300) begin @(negedge clk); b++; end
        if (b >= 300) chk("stop_timeout", b, 0);
        tick(2);
    endtask

    task automatic start(input int n, input int v);
        nin = 8'(n); sv = 1'(v); run = 1'b1;
    endtask

    initial begin
        int c;
        tick(3);
        chk("reset_outputs", (dut_vec() == RST_VEC) ? 1 : 0, 1);
        rst = 1'b0;
        tick(2);

        // N=16: latency, config, stop at cnt 3 with re-rise in DRAIN
        start(16, 1);
        tick(1);
        chk("prime_not_active", int'(active), 0);
        chk("cfg_stages16", int'(stages), 2);
        tick(1);
        chk("first_stb_a_in", int'(stb_a_in), 1);
        chk("first_active", int'(active), 1);
        chk("cic16", int'(cic_rate), 4);
        chk("rate_a16", int'(rate_a), 8);
        chk("rate_b16", int'(rate_b), 4);
        chk("bypass16", int'({bypass_a, bypass_b}), 0);
        c = 0;
        tick(1);
        for (int i = 1; i < 16; i++) begin
            if (stb_cic) c++;
            tick(1);
        end
        chk("cic_pulses_per_period16", c, 3); // cnt 4, 8, 12 within 1..15
        wait_ph(3);
        run = 1'b0;
        c = 0;
        while (!done && c < 100) begin
            @(negedge clk); c++;
            if (c == 3) run = 1'b1;
        end
        chk("drain_to_done_cycles", c, 13);
        tick(1);
        chk("done_one_cycle", int'(done), 0);
        tick(4);
        chk("rerise_ignored", int'(active), 0);
        run = 1'b0;
        tick(2);

        // N=10 and N=12: single halfband
        start(10, 1);
        tick(2);
        chk("cfg_stages10", int'(stages), 1);
        chk("cic10", int'(cic_rate), 5);
        chk("bypass10", int'({bypass_a, bypass_b}), 2'b01);
        tick(25);
        stop_and_idle();
        start(12, 1);
        tick(2);
        chk("cic12", int'(cic_rate), 6);
        tick(20);
        stop_and_idle();

        // N=7: no halfbands
        start(7, 1);
        tick(2);
        chk("cfg_stages7", int'(stages), 0);
        chk("bypass7", int'({bypass_a, bypass_b}), 2'b11);
        chk("cic7", int'(cic_rate), 7);
        tick(20);
        stop_and_idle();

        // N=0: config error
        start(0, 1);
        tick(4);
        chk("cfg_err0", int'(cfg_err), 1);
        chk("n0_idle", int'(active), 0);
        run = 1'b0;
        tick(2);

        // Underrun: one empty period start
        start(16, 1);
        wait_ph(15);
        sv = 1'b0;
        zf_cnt = 0;
        tick(1);
        sv = 1'b1;
        chk("underrun_set", int'(underrun), 1);
        tick(40);
        chk("zero_fill_len", zf_cnt, 16);
        chk("underrun_sticky", int'(underrun), 1);
        stop_and_idle();

        // Randomized runs
        for (int it = 0; it < 14; it++) begin
            start($urandom_range(0, 40), $urandom_range(0, 1));
            for (int cy = 0; cy < 80; cy++) begin
                tick(1);
                sv = ($urandom_range(0, 7) != 0);
                if ($urandom_range(0, 60) == 0) run = 1'b0;
            end
            stop_and_idle();
        end

        // Asynchronous reset mid-run, then restart
        start(16, 1);
        wait_ph(5);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_outputs", (dut_vec() == RST_VEC) ? 1 : 0, 1);
        tick(2);
        rst = 1'b0;
        run = 1'b0;
        tick(2);
        start(12, 1);
        tick(2);
        chk("restart_active", int'(active), 1);
        chk("restart_stages", int'(stages), 1);
        tick(15);
        stop_and_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
